// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the five-stage pipelined core.
//
// Holds the PC, a word-addressed instruction memory with a load port, the
// IF/ID pipeline register, the load-use hazard detector and a saturating
// stall-cycle counter for performance debug.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   imem_we         instruction memory load write enable
//   imem_waddr      load word address (AW bits)
//   imem_wdata      load data word
//   mem_read_s2     ID/EX instruction is a load
//   rt_s2           destination register of the ID/EX load
//   branch_taken    EX-stage redirect request (highest priority)
//   branch_target   redirect address, low two bits ignored
//   pc              current PC (registered)
//   pc_out1         pc + 4 (combinational, wraps modulo 2^32)
//   instruction     memory word at pc, NOP when pc is past the memory
//   instruction_s1  IF/ID instruction
//   pc_out1_s1      IF/ID copy of pc + 4
//   valid_s1        IF/ID holds a real instruction
//   stall           load-use hazard, decode injects a bubble into ID/EX
//   flush           IF/ID is cleared this cycle (mirrors branch_taken)
//   stall_cnt       saturating count of stall cycles
// ---------------------------------------------------------------------------
module if_stage #(
   parameter int          IMEM_DEPTH = 64,
   parameter int          AW         = $clog2(IMEM_DEPTH),
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          imem_we,
   input  logic [AW-1:0] imem_waddr,
   input  logic [31:0]   imem_wdata,
   input  logic          mem_read_s2,
   input  logic [4:0]    rt_s2,
   input  logic          branch_taken,
   input  logic [31:0]   branch_target,
   output logic [31:0]   pc,
   output logic [31:0]   pc_out1,
   output logic [31:0]   instruction,
   output logic [31:0]   instruction_s1,
   output logic [31:0]   pc_out1_s1,
   output logic          valid_s1,
   output logic          stall,
   output logic          flush,
   output logic [15:0]   stall_cnt
);

   // Instruction memory: not reset, written only through the load port.
   logic [31:0] imem [0:IMEM_DEPTH-1];

   always_ff @(posedge clk) begin
      if (imem_we)
         imem[imem_waddr] <= imem_wdata;
   end

   // Fetch read is asynchronous, so a same-cycle write is seen only from
   // the following cycle. Addresses beyond the memory fetch a NOP.
   logic in_range;
   assign in_range    = (pc[31:2] < 30'(IMEM_DEPTH));
   assign instruction = in_range ? imem[pc[AW+1:2]] : 32'h0;
   assign pc_out1     = pc + 32'd4;

   // Load-use hazard against the source fields of the instruction in IF/ID.
   // Register 0 is never a real dependency.
   logic [4:0] rs_s1;
   logic [4:0] rt_s1;
   assign rs_s1 = instruction_s1[25:21];
   assign rt_s1 = instruction_s1[20:16];
   assign stall = valid_s1 & mem_read_s2 & (rt_s2 != 5'd0) &
                  ((rt_s2 == rs_s1) | (rt_s2 == rt_s1));

   assign flush = branch_taken;

   // The redirect target is word aligned; its low bits are dropped.
   logic unused_tgt_lsb;
   assign unused_tgt_lsb = ^branch_target[1:0];

   // Redirect beats stall: a taken branch squashes the stalled instruction,
   // so that cycle is not counted as a stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc             <= RESET_PC;
         instruction_s1 <= 32'h0;
         pc_out1_s1     <= 32'h0;
         valid_s1       <= 1'b0;
         stall_cnt      <= 16'h0;
      end else if (branch_taken) begin
         pc             <= {branch_target[31:2], 2'b00};
         instruction_s1 <= 32'h0;
         pc_out1_s1     <= 32'h0;
         valid_s1       <= 1'b0;
      end else if (stall) begin
         if (stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end else begin
         pc             <= pc_out1;
         instruction_s1 <= instruction;
         pc_out1_s1     <= pc_out1;
         valid_s1       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_we = 1'b0;
   logic [5:0]  imem_waddr = '0;
   logic [31:0] imem_wdata = '0;
   logic        mem_read_s2 = 1'b0;
   logic [4:0]  rt_s2 = '0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] pc, pc_out1, instruction, instruction_s1, pc_out1_s1;
   logic        valid_s1, stall, flush;
   logic [15:0] stall_cnt;

   if_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .mem_read_s2(mem_read_s2), .rt_s2(rt_s2),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .pc_out1(pc_out1), .instruction(instruction),
      .instruction_s1(instruction_s1), .pc_out1_s1(pc_out1_s1),
      .valid_s1(valid_s1), .stall(stall), .flush(flush), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_mem [0:DEPTH-1];
   logic [31:0] m_pc, m_ir, m_pc1;
   logic        m_v;
   int          m_cnt;

   function automatic logic [31:0] m_fetch(input logic [31:0] a);
      if ((a / 4) < DEPTH) return m_mem[a[7:2]];
      return 32'h0;
   endfunction

   function automatic logic m_hazard(input logic mr, input logic [4:0] rt);
      int rs_f, rt_f;
      rs_f = (m_ir / 32'h0020_0000) % 32;
      rt_f = (m_ir / 32'h0001_0000) % 32;
      return m_v && mr && rt != 0 && (int'(rt) == rs_f || int'(rt) == rt_f);
   endfunction

   task automatic m_reset();
      m_pc = 0; m_ir = 0; m_pc1 = 0; m_v = 0; m_cnt = 0;
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, " pc"}, pc, m_pc);
      chk({tag, " instruction_s1"}, instruction_s1, m_ir);
      chk({tag, " pc_out1_s1"}, pc_out1_s1, m_pc1);
      chk({tag, " valid_s1"}, 32'(valid_s1), 32'(m_v));
      chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
   endtask

   // One clock: drive inputs, check combinational outputs, advance model
   // and DUT, then check registered state.
   task automatic step(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic mr, input logic [4:0] rt,
                       input logic bt, input logic [31:0] tgt);
      logic [31:0] e_ins;
      logic        e_st;
      imem_we = we; imem_waddr = wa; imem_wdata = wd;
      mem_read_s2 = mr; rt_s2 = rt; branch_taken = bt; branch_target = tgt;
      #1;
      e_ins = m_fetch(m_pc);
      e_st  = m_hazard(mr, rt);
      chk("instruction", instruction, e_ins);
      chk("pc_out1", pc_out1, m_pc + 32'd4);
      chk("stall", 32'(stall), 32'(e_st));
      chk("flush", 32'(flush), 32'(bt));
      if (bt) begin
         m_pc = tgt & 32'hFFFF_FFFC; m_ir = 0; m_pc1 = 0; m_v = 0;
      end else if (e_st) begin
         if (m_cnt < 65535) m_cnt++;
      end else begin
         m_ir = e_ins; m_pc1 = m_pc + 32'd4; m_v = 1; m_pc = m_pc + 32'd4;
      end
      if (we) m_mem[wa] = wd;
      @(posedge clk); #1;
      imem_we = 1'b0;
      chk_regs("step");
   endtask

   task automatic fetch();
      step(1'b0, 6'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      step(1'b0, 6'd0, 32'h0, 1'b0, 5'd0, 1'b1, tgt);
   endtask

   typedef struct {
      logic       mr;
      logic [4:0] rt;
      logic       exp_stall;
   } hz_vec_t;

   initial begin
      hz_vec_t hz [6];
      logic [31:0] hold_pc, hold_ir;
      logic [4:0]  rtv;

      hz[0] = '{1'b1, 5'd1, 1'b1};
      hz[1] = '{1'b1, 5'd2, 1'b1};
      hz[2] = '{1'b1, 5'd0, 1'b0};
      hz[3] = '{1'b1, 5'd3, 1'b0};
      hz[4] = '{1'b0, 5'd1, 1'b0};
      hz[5] = '{1'b0, 5'd2, 1'b0};

      // Preload imem through the load port while reset is held.
      m_reset();
      for (int i = 0; i < DEPTH; i++) begin
         logic [31:0] w;
         case (i)
            0: w = 32'h1111_1111;
            1: w = 32'h2222_2222;
            2: w = 32'h3333_3333;
            3: w = 32'h4444_4444;
            4: w = 32'h0022_1820;
            8: w = 32'h8888_8888;
            default: w = $urandom;
         endcase
         imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = w; m_mem[i] = w;
         @(posedge clk); #1;
      end
      imem_we = 1'b0;

      // Reset state.
      #1;
      chk("rst pc", pc, 32'h0);
      chk("rst pc_out1", pc_out1, 32'h4);
      chk("rst instruction_s1", instruction_s1, 32'h0);
      chk("rst pc_out1_s1", pc_out1_s1, 32'h0);
      chk("rst valid_s1", 32'(valid_s1), 32'h0);
      chk("rst stall_cnt", 32'(stall_cnt), 32'h0);
      chk("rst stall", 32'(stall), 32'h0);
      reset = 1'b1;

      // Sequential fetch.
      fetch(); chk("seq1 ir", instruction_s1, 32'h1111_1111); chk("seq1 pc", pc, 32'h4);
      fetch(); chk("seq2 ir", instruction_s1, 32'h2222_2222); chk("seq2 pc1", pc_out1_s1, 32'h8);
      fetch(); chk("seq3 ir", instruction_s1, 32'h3333_3333); chk("seq3 pc", pc, 32'hC);
      fetch(); fetch();
      chk("lu ir", instruction_s1, 32'h0022_1820);

      // Load-use hazard table (combinational, no edge).
      foreach (hz[i]) begin
         mem_read_s2 = hz[i].mr; rt_s2 = hz[i].rt; #1;
         chk($sformatf("hz vec %0d", i), 32'(stall), 32'(hz[i].exp_stall));
      end

      // Stall over an edge: pc and IF/ID hold, counter increments.
      step(1'b0, 6'd0, 32'h0, 1'b1, 5'd1, 1'b0, 32'h0);
      chk("stall pc", pc, 32'h14);
      chk("stall ir", instruction_s1, 32'h0022_1820);
      chk("stall cnt", 32'(stall_cnt), 32'h1);

      // Branch wins over a simultaneous stall.
      step(1'b0, 6'd0, 32'h0, 1'b1, 5'd2, 1'b1, 32'h23);
      chk("bos pc", pc, 32'h20);
      chk("bos valid", 32'(valid_s1), 32'h0);
      chk("bos ir", instruction_s1, 32'h0);
      chk("bos cnt", 32'(stall_cnt), 32'h1);
      fetch(); chk("bos next ir", instruction_s1, 32'h8888_8888);

      // Out of range fetch returns NOP; PC wraps at the top.
      redirect(32'h100);
      #1 chk("oor instruction", instruction, 32'h0);
      fetch(); chk("oor ir", instruction_s1, 32'h0); chk("oor valid", 32'(valid_s1), 32'h1);
      redirect(32'hFFFF_FFFC);
      fetch(); chk("wrap pc", pc, 32'h0);
      repeat (4) fetch();
      chk("pre-reset pc", pc, 32'h10);

      // Async reset between edges.
      #2 reset = 1'b0;
      #1;
      m_reset();
      chk("async pc", pc, 32'h0);
      chk("async valid", 32'(valid_s1), 32'h0);
      chk("async cnt", 32'(stall_cnt), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      fetch(); chk("resume ir", instruction_s1, 32'h1111_1111);

      // Write collision: IF/ID takes the old word; new word visible later.
      step(1'b1, 6'd1, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 32'h0);
      chk("coll ir", instruction_s1, 32'h2222_2222);
      redirect(32'h4);
      fetch(); chk("coll new ir", instruction_s1, 32'hDEAD_BEEF);

      // Saturation: hold the hazard (rs field of DEADBEEF is 21).
      hold_pc = pc; hold_ir = instruction_s1;
      mem_read_s2 = 1'b1; rt_s2 = 5'd21; branch_taken = 1'b0;
      #1 chk("sat stall", 32'(stall), 32'h1);
      repeat (65540) @(posedge clk);
      #1;
      chk("sat cnt", 32'(stall_cnt), 32'hFFFF);
      chk("sat pc", pc, hold_pc);
      chk("sat ir", instruction_s1, hold_ir);
      m_cnt = 65535;
      step(1'b0, 6'd0, 32'h0, 1'b1, 5'd21, 1'b0, 32'h0);

      // Randomized run against the model.
      reset = 1'b0; #1; m_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      for (int n = 0; n < 600; n++) begin
         logic        we, mr, bt;
         logic [31:0] tgt;
         we = ($urandom_range(0, 3) == 0);
         mr = $urandom_range(0, 1);
         bt = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0: rtv = 5'd0;
            1: rtv = m_ir[25:21];
            2: rtv = m_ir[20:16];
            default: rtv = 5'($urandom);
         endcase
         tgt = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom_range(0, 300));
         step(we, 6'($urandom), $urandom, mr, rtv, bt, tgt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipelined RISC core: owns the PC register, a word-addressed instruction memory with a load port, the IF/ID pipeline register and the load-use hazard detector. It feeds the decode stage (instruction_s1, pc_out1_s1) and takes redirect and hazard inputs from the ID/EX and EX stages. Branch redirects take priority over stalls, and a saturating counter records stall cycles for performance debug.

## Interface
- IMEM_DEPTH, 64: instruction memory depth in 32-bit words; power of two, 16 to 1024.
- AW, $clog2(IMEM_DEPTH): width of the imem load address.
- RESET_PC, 32'h0000_0000: PC value after reset; must be word-aligned.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_we  in  1  instruction memory load write enable.
- imem_waddr  in  AW  word address for the load write.
- imem_wdata  in  32  word to write.
- mem_read_s2  in  1  instruction in ID/EX is a load.
- rt_s2  in  5  destination register of the ID/EX load.
- branch_taken  in  1  EX-stage redirect request.
- branch_target  in  32  redirect address; bits [1:0] ignored.
- pc  out  32  current PC (registered).
- pc_out1  out  32  pc + 4 (combinational, modulo 2^32).
- instruction  out  32  memory word at pc (combinational).
- instruction_s1  out  32  IF/ID instruction.
- pc_out1_s1  out  32  IF/ID copy of PC+4.
- valid_s1  out  1  IF/ID holds a real instruction.
- stall  out  1  load-use hazard; decode must inject a bubble into ID/EX.
- flush  out  1  equals branch_taken; IF/ID is being cleared this cycle.
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Fetch read: instruction = imem[pc[AW+1:2]] when pc[31:2] < IMEM_DEPTH, else 32'h0 (NOP). Read is combinational and returns the old contents during a same-cycle write.
- Load port: on a rising edge with imem_we=1, imem[imem_waddr] <= imem_wdata. Memory contents are not affected by reset.
- Hazard: rs_s1 = instruction_s1[25:21], rt_s1 = instruction_s1[20:16]. stall = valid_s1 & mem_read_s2 & (rt_s2 != 0) & (rt_s2 == rs_s1 | rt_s2 == rt_s1). The value is combinational.
- Next-state priority at each rising edge:
  1. branch_taken: pc <= {branch_target[31:2], 2'b00}. IF/ID <= bubble (instruction_s1=0, pc_out1_s1=0, valid_s1=0). The stall is overridden and stall_cnt is unchanged.
  2. stall, with no branch: pc holds and IF/ID holds. stall_cnt <= stall_cnt+1, saturating at 16'hFFFF.
  3. Otherwise: pc <= pc_out1. IF/ID <= {instruction, pc_out1, valid=1}.
- PC wrap: 32'hFFFF_FFFC + 4 wraps to 0, with no error.
- Reset (async, reset=0): pc=RESET_PC, instruction_s1=0, pc_out1_s1=0, valid_s1=0, stall_cnt=0. Consequently stall=0, flush follows branch_taken, and pc_out1=RESET_PC+4. Reset asserted mid-operation takes effect immediately without waiting for clk. The first update happens on the first rising edge after reset goes high.

## Timing
- Fetch latency: one cycle. The word at pc appears on instruction_s1 after the next rising edge.
- Redirect: branch_taken sampled at edge N sets pc=target at N. That instruction reaches instruction_s1 at N+1, so one bubble is inserted.
- Stall: held for every cycle the hazard condition is true. It normally lasts one cycle, because decode's bubble clears mem_read_s2.
- A write to the address being fetched in the same cycle: IF/ID captures the old word; the new word is visible from the next cycle.
- No handshake beyond stall and flush. All inputs must be stable before the rising edge.

## Test plan
- Sequential fetch: preload imem[0..3]=32'h11111111, 22222222, 33333333, 44444444, then release reset. After edges 1, 2, 3: instruction_s1 = 11111111, 22222222, 33333333; pc_out1_s1 = 4, 8, 12; pc = 4, 8, 12; valid_s1=1.
- Load-use: instruction_s1=32'h00221820, mem_read_s2=1, rt_s2=1 (or 2) -> stall=1, pc and IF/ID unchanged over the edge, stall_cnt +1. rt_s2=0 or 3 -> stall=0.
- Branch over stall: the load-use condition and branch_taken=1 with branch_target=32'h23 at the same edge -> pc=32'h20, valid_s1=0, instruction_s1=0, stall_cnt unchanged. Next edge: instruction_s1=imem[8].
- Out of range and wrap: redirect to 32'h100 with IMEM_DEPTH=64 -> instruction=0 and instruction_s1=0 next cycle. Redirect to 32'hFFFFFFFC -> the following pc is 0.
- Async reset mid-run: drive reset low between edges while pc=32'h10 -> pc=0, valid_s1=0, stall_cnt=0 immediately. Release reset and fetch resumes from imem[0].
- Saturation and write collision: hold the hazard for 65540 cycles -> stall_cnt stays 16'hFFFF. Write imem[pc>>2] with a new word in the fetch cycle -> IF/ID captures the old word.
